// File: rtl/mem_seq_pkg.sv
// ============================================================================
// Module : mem_seq_pkg
// Brief  : Shared types and constants for the memory sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_seq_pkg;

  localparam int c_XLEN             = 32;
  localparam int c_WAIT_MAX_DEFAULT = 15;
  localparam int c_WAIT_W           = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10,
    ERR   = 2'b11
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_seq_if.sv
// ============================================================================
// Module : mem_seq_if
// Brief  : Single-port memory bus between the sequencer (master) and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_seq_if;
  import mem_seq_pkg::*;

  logic              m_req;
  logic              m_we;
  logic [c_XLEN-1:0] m_addr;
  logic [c_XLEN-1:0] m_wdata;
  logic [c_XLEN-1:0] m_rdata;
  logic              m_ready;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ready
  );

endinterface

`default_nettype wire

// File: rtl/mem_seq_timer.sv
// ============================================================================
// Module : mem_seq_timer
// Brief  : Counts memory wait cycles of one access; flags the last allowed one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_seq_timer
  import mem_seq_pkg::*;
#(
  parameter int WAIT_MAX = c_WAIT_MAX_DEFAULT
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clear,
  input  wire logic i_count_en,
  output logic      o_expired
);

  localparam logic [c_WAIT_W-1:0] c_LAST_WAIT = c_WAIT_W'(WAIT_MAX - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_CAP  = c_WAIT_W'(WAIT_MAX);

  logic [c_WAIT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != c_WAIT_CAP)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The wait that would bring the count to WAIT_MAX is the one that times out.
  assign o_expired = i_count_en && (r_count == c_LAST_WAIT);

endmodule

`default_nettype wire

// File: rtl/mem_sequencer.sv
// ============================================================================
// Module : mem_sequencer
// Brief  : Arbitrates instruction fetch and data access onto one memory port.
// Config : MEM_SEQ_TIMEOUT_EN adds a wait-cycle timeout with a sticky ERR state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int WAIT_MAX = c_WAIT_MAX_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [c_XLEN-1:0] pc,
  input  wire logic              if_req,
  output logic      [c_XLEN-1:0] instr,
  output logic                   if_valid,
  input  wire logic              d_req,
  input  wire logic              d_we,
  input  wire logic [c_XLEN-1:0] d_addr,
  input  wire logic [c_XLEN-1:0] d_wdata,
  output logic      [c_XLEN-1:0] d_rdata,
  output logic                   d_valid,
  output logic                   stall,
  output logic                   err,
  mem_seq_if.master              mem
);

  if ((WAIT_MAX < 1) || (WAIT_MAX > 255)) begin : g_wait_max_range
    $error("mem_sequencer: WAIT_MAX must lie in 1..255");
  end

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [c_XLEN-1:0] r_addr;
  logic [c_XLEN-1:0] r_wdata;
  logic [c_XLEN-1:0] r_instr;
  logic [c_XLEN-1:0] r_d_rdata;
  logic              r_we;
  logic              r_if_valid;
  logic              r_d_valid;
  logic              w_in_access;
  logic              w_grant_data;
  logic              w_grant_fetch;
  logic              w_timeout;
  logic              w_err;

  // Data has fixed priority over fetch; grants only happen from IDLE.
  assign w_grant_data  = (r_state == IDLE) && d_req;
  assign w_grant_fetch = (r_state == IDLE) && !d_req && if_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (d_req) begin
          w_next_state = DATA;
        end else if (if_req) begin
          w_next_state = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem.m_ready) begin
          w_next_state = IDLE;
        end else if (w_timeout) begin
          w_next_state = ERR;
        end
      end
      ERR:     w_next_state = ERR;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_in_access = 1'b0;
    mem.m_we    = 1'b0;
    case (r_state)
      FETCH: w_in_access = 1'b1;
      DATA: begin
        w_in_access = 1'b1;
        mem.m_we    = r_we;
      end
      default: ;
    endcase
  end

  assign mem.m_req   = w_in_access;
  assign mem.m_addr  = r_addr;
  assign mem.m_wdata = r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_instr    <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (w_grant_data) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
      end else if (w_grant_fetch) begin
        r_addr  <= pc;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end
      if ((r_state == FETCH) && mem.m_ready) begin
        r_instr    <= mem.m_rdata;
        r_if_valid <= 1'b1;
      end
      // Stores complete with a pulse but keep the last load data.
      if ((r_state == DATA) && mem.m_ready) begin
        r_d_valid <= 1'b1;
        if (!r_we) begin
          r_d_rdata <= mem.m_rdata;
        end
      end
    end
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  logic w_wait;

  assign w_wait = w_in_access && !mem.m_ready;

  mem_seq_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_grant_data || w_grant_fetch),
    .i_count_en (w_wait),
    .o_expired  (w_timeout)
  );

  assign w_err = (r_state == ERR);
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  assign instr    = r_instr;
  assign if_valid = r_if_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;
  assign err      = w_err;
  assign stall    = (if_req && !r_if_valid) || (d_req && !r_d_valid) || w_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_sequencer.sv
// ============================================================================
// Module : tb_mem_sequencer
// Brief  : Self-checking bench for mem_sequencer with an access-level model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_sequencer;
  import mem_seq_pkg::*;

  localparam int WAIT_MAX = 15;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic [31:0] pc      = '0;
  logic        if_req  = 1'b0;
  logic [31:0] instr;
  logic        if_valid;
  logic        d_req   = 1'b0;
  logic        d_we    = 1'b0;
  logic [31:0] d_addr  = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        err;

  mem_seq_if mem ();

  mem_sequencer #(
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .if_req   (if_req),
    .instr    (instr),
    .if_valid (if_valid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .stall    (stall),
    .err      (err),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int iv_count = 0;
  int dv_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access-level model: one access outstanding at a time, data wins in idle.
  logic        md_busy   = 1'b0;
  logic        md_data   = 1'b0;
  logic        md_we     = 1'b0;
  logic [31:0] md_addr   = '0;
  logic [31:0] md_wdata  = '0;
  logic [31:0] md_instr  = '0;
  logic [31:0] md_drdata = '0;
  logic        md_ifv    = 1'b0;
  logic        md_dv     = 1'b0;
  logic        md_err    = 1'b0;
  int          md_waits  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_busy   <= 1'b0;
      md_data   <= 1'b0;
      md_we     <= 1'b0;
      md_addr   <= '0;
      md_wdata  <= '0;
      md_instr  <= '0;
      md_drdata <= '0;
      md_ifv    <= 1'b0;
      md_dv     <= 1'b0;
      md_err    <= 1'b0;
      md_waits  <= 0;
    end else begin
      md_ifv <= 1'b0;
      md_dv  <= 1'b0;
      if (md_err) begin
        md_waits <= md_waits;
      end else if (md_busy) begin
        if (mem.m_ready) begin
          md_busy <= 1'b0;
          if (md_data) begin
            md_dv <= 1'b1;
            if (!md_we) md_drdata <= mem.m_rdata;
          end else begin
            md_ifv   <= 1'b1;
            md_instr <= mem.m_rdata;
          end
        end else begin
`ifdef MEM_SEQ_TIMEOUT_EN
          if (md_waits + 1 == WAIT_MAX) begin
            md_busy <= 1'b0;
            md_err  <= 1'b1;
          end
`endif
          md_waits <= md_waits + 1;
        end
      end else if (d_req) begin
        md_busy  <= 1'b1;
        md_data  <= 1'b1;
        md_we    <= d_we;
        md_addr  <= d_addr;
        md_wdata <= d_wdata;
        md_waits <= 0;
      end else if (if_req) begin
        md_busy  <= 1'b1;
        md_data  <= 1'b0;
        md_we    <= 1'b0;
        md_addr  <= pc;
        md_waits <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("m_req", 32'(mem.m_req), 32'(md_busy));
    check("m_we", 32'(mem.m_we), 32'(md_busy && md_data && md_we));
    if (md_busy) check("m_addr", mem.m_addr, md_addr);
    if (md_busy && md_data) check("m_wdata", mem.m_wdata, md_wdata);
    check("instr", instr, md_instr);
    check("d_rdata", d_rdata, md_drdata);
    check("if_valid", 32'(if_valid), 32'(md_ifv));
    check("d_valid", 32'(d_valid), 32'(md_dv));
    check("stall", 32'(stall), 32'((if_req && !md_ifv) || (d_req && !md_dv) || md_err));
    check("err", 32'(err), 32'(md_err));
    if (if_valid) iv_count++;
    if (d_valid)  dv_count++;
  end

  int          t0;
  int          dv0;
  logic [31:0] saved;

  initial begin
    mem.m_ready = 1'b0;
    mem.m_rdata = '0;

    // Reset state
    repeat (2) tick();
    check("rst m_req", 32'(mem.m_req), 32'd0);
    check("rst m_addr", mem.m_addr, 32'h0);
    check("rst m_wdata", mem.m_wdata, 32'h0);
    check("rst instr", instr, 32'h0);
    check("rst err", 32'(err), 32'd0);
    reset = 1'b1;
    tick();

    // Zero-wait fetch
    pc = 32'h10; if_req = 1'b1; t0 = cyc;
    tick();
    check("fetch m_req", 32'(mem.m_req), 32'd1);
    check("fetch m_addr", mem.m_addr, 32'h10);
    mem.m_ready = 1'b1; mem.m_rdata = 32'h0010_0293;
    tick();
    mem.m_ready = 1'b0; mem.m_rdata = 32'hBAD0_BAD0;
    check("fetch if_valid", 32'(if_valid), 32'd1);
    check("fetch instr", instr, 32'h0010_0293);
    check("fetch latency", 32'(cyc - t0), 32'd2);
    if_req = 1'b0;
    tick();

    // Store with three wait cycles; inputs change after grant
    saved = d_rdata; dv0 = dv_count;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick();
    d_addr = 32'hFFFF_0000; d_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("store m_we", 32'(mem.m_we), 32'd1);
      check("store m_addr", mem.m_addr, 32'h40);
      check("store m_wdata", mem.m_wdata, 32'hDEAD_BEEF);
      mem.m_ready = (i == 3); mem.m_rdata = 32'h5555_AAAA;
      tick();
    end
    mem.m_ready = 1'b0;
    check("store d_valid", 32'(d_valid), 32'd1);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) tick();
    check("store d_valid once", 32'(dv_count - dv0), 32'd1);
    check("store d_rdata kept", d_rdata, saved);

    // Simultaneous fetch and load: data first, bubble, then fetch
    pc = 32'h20; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h80;
    tick();
    check("both data m_addr", mem.m_addr, 32'h80);
    check("both data m_we", 32'(mem.m_we), 32'd0);
    mem.m_ready = 1'b1; mem.m_rdata = 32'h1111_2222;
    tick();
    mem.m_ready = 1'b0;
    check("both d_valid", 32'(d_valid), 32'd1);
    check("both d_rdata", d_rdata, 32'h1111_2222);
    check("both bubble", 32'(mem.m_req), 32'd0);
    check("both stall", 32'(stall), 32'd1);
    d_req = 1'b0;
    tick();
    check("both fetch m_req", 32'(mem.m_req), 32'd1);
    check("both fetch m_addr", mem.m_addr, 32'h20);
    mem.m_ready = 1'b1; mem.m_rdata = 32'h3333_4444;
    tick();
    mem.m_ready = 1'b0;
    check("both if_valid", 32'(if_valid), 32'd1);
    check("both instr", instr, 32'h3333_4444);
    check("both stall low", 32'(stall), 32'd0);
    if_req = 1'b0;
    tick();

    // Request held through the valid pulse restarts an access
    pc = 32'h30; if_req = 1'b1;
    tick();
    mem.m_ready = 1'b1; mem.m_rdata = 32'hAAAA_0001;
    tick();
    mem.m_ready = 1'b0;
    tick();
    check("held restart m_req", 32'(mem.m_req), 32'd1);
    mem.m_ready = 1'b1; mem.m_rdata = 32'hAAAA_0002;
    tick();
    mem.m_ready = 1'b0; if_req = 1'b0;
    check("held second instr", instr, 32'hAAAA_0002);
    tick();

    // Reset during a data wait aborts without a valid pulse
    dv0 = dv_count;
    d_req = 1'b1; d_addr = 32'h100;
    repeat (2) tick();
    check("abort m_req before", 32'(mem.m_req), 32'd1);
    reset = 1'b0;
    #1;
    check("abort m_req async", 32'(mem.m_req), 32'd0);
    mem.m_ready = 1'b1;
    tick();
    mem.m_ready = 1'b0; d_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort idle", 32'(mem.m_req), 32'd0);
    check("abort no d_valid", 32'(dv_count - dv0), 32'd0);

    // m_ready while idle is ignored
    saved = instr;
    mem.m_ready = 1'b1; mem.m_rdata = 32'hCAFE_F00D;
    repeat (2) tick();
    mem.m_ready = 1'b0;
    check("idle ready m_req", 32'(mem.m_req), 32'd0);
    check("idle ready instr", instr, saved);
    tick();

    // Memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    tick();
`ifdef MEM_SEQ_TIMEOUT_EN
    for (int i = 0; i < WAIT_MAX; i++) begin
      check("timeout m_req held", 32'(mem.m_req), 32'd1);
      check("timeout err early", 32'(err), 32'd0);
      tick();
    end
    check("timeout err", 32'(err), 32'd1);
    check("timeout m_req", 32'(mem.m_req), 32'd0);
    check("timeout stall", 32'(stall), 32'd1);
    d_req = 1'b0; mem.m_ready = 1'b1;
    repeat (3) tick();
    mem.m_ready = 1'b0;
    check("timeout err sticky", 32'(err), 32'd1);
    check("timeout stall sticky", 32'(stall), 32'd1);
`else
    for (int i = 0; i < WAIT_MAX + 5; i++) begin
      check("no-timeout m_req", 32'(mem.m_req), 32'd1);
      check("no-timeout err", 32'(err), 32'd0);
      tick();
    end
    d_req = 1'b0;
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("final err", 32'(err), 32'd0);
    check("final m_req", 32'(mem.m_req), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
